serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 79 +++++++
 1 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial a+b+cin, LSB first, one full-adder stage and one carry flop.
// Optional ovf port and logic are built when SERIAL_ADDER_OVF_EN is defined.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,output logic            ovf
`endif
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, res;
    logic [WIDTH-2:0] acc;
    logic [CW-1:0]    cnt;
    logic             carry, fa_s, fa_c, last;

    always_comb begin
        fa_s      = a_sh[0] ^ b_sh[0] ^ carry;
        fa_c      = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
        res       = {fa_s, acc};
        last      = cnt == CW'(WIDTH - 1);
        busy      = state == SHIFT;
        done      = state == DONE;
        state_nxt = (state == SHIFT) ? (last ? DONE : SHIFT) : (start ? SHIFT : IDLE);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    // acc collects sum bits MSB-in; sum/cout/ovf only load on the final bit so partial results never show
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (state != SHIFT) begin
            if (start) begin
                a_sh  <= a;
                b_sh  <= b;
                carry <= cin;
                cnt   <= '0;
            end
        end else begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            carry <= fa_c;
            acc   <= res[WIDTH-1:1];
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum  <= res;
                cout <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                ovf  <= carry ^ fa_c;
`endif
            end
        end
    end
endmodule
